// File: rtl/skid_pkg.sv
// Shared types for the skid buffer: FSM state encoding and occupancy counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package skid_pkg;

    // Occupancy counter width; it holds 0, 1 or 2 words.
    localparam int COUNT_W = 2;

    // EMPTY: nothing held. ONE: main valid. FULL: main and skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Number of words held in a given state.
    function automatic logic [COUNT_W-1:0] state_count(input state_t s);
        logic [COUNT_W-1:0] c;
        case (s)
            ONE:     c = 2'd1;
            FULL:    c = 2'd2;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/skid_buffer_data_reg.sv
// WIDTH-bit storage register with load enable, cleared to zero on reset.
// Latency: 1 cycle from load to q.
// Backpressure: none; holds its value whenever load is low.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   load      capture d on the next rising edge
//   d         next value
//   q         stored value
module data_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry skid buffer that fully registers a valid/ready channel in both directions.
// Latency: 1 cycle from an accepted input to out_valid; sustains 1 word/cycle.
// Backpressure: in_ready is a flop that drops only when both entries are held, so
//               out_ready never reaches in_ready combinationally; the skid entry
//               absorbs the word that arrives in the cycle the stall is noticed.
//
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload (from main register)
//   count                words currently held (0, 1 or 2)
module skid_buffer
    import skid_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] count
);

    state_t             state;
    state_t             next_state;

    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [COUNT_W-1:0] count_reg;

    logic               in_xfer;
    logic               out_xfer;

    logic               load_main;
    logic               load_skid;
    logic               main_from_skid;
    logic [WIDTH-1:0]   main_d;
    logic [WIDTH-1:0]   main_q;
    logic [WIDTH-1:0]   skid_q;

    // Handshakes use only registered ready/valid, so a transfer is decided
    // purely by flops plus the partner's input.
    assign in_xfer  = in_valid && in_ready_reg;
    assign out_xfer = out_valid_reg && out_ready;

    // State register. The handshake outputs are flopped from next_state so
    // they are true registers rather than decodes of the state vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            count_reg     <= '0;
        end else begin
            state         <= next_state;
            in_ready_reg  <= (next_state != FULL);
            out_valid_reg <= (next_state != EMPTY);
            count_reg     <= state_count(next_state);
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            EMPTY: begin
                if (in_xfer) next_state = ONE;
            end
            ONE: begin
                if (in_xfer && !out_xfer)      next_state = FULL;
                else if (!in_xfer && out_xfer) next_state = EMPTY;
            end
            FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_xfer) next_state = ONE;
            end
            default: next_state = EMPTY;
        endcase
    end

    // Datapath control.
    always_comb begin
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                load_main = in_xfer;
            end
            ONE: begin
                // Head leaving with a new word arriving: the new word becomes
                // the head. Head staying: the new word parks in skid.
                load_main = in_xfer && out_xfer;
                load_skid = in_xfer && !out_xfer;
            end
            FULL: begin
                load_main      = out_xfer;
                main_from_skid = 1'b1;
            end
            default: begin
                load_main = 1'b0;
            end
        endcase
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    data_reg #(.WIDTH(WIDTH)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (load_main),
        .d    (main_d),
        .q    (main_q)
    );

    data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (load_skid),
        .d    (in_data),
        .q    (skid_q)
    );

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = main_q;
    assign count     = count_reg;

endmodule

// File: tb/tb_skid_buffer.sv
// Testbench for skid_buffer: directed scenarios on an 8-bit instance plus
// random valid/ready traffic on 8-bit and 1-bit instances against a queue model.
module tb_skid_buffer;

    logic       clk;
    logic       rst;

    logic       a_in_valid;
    logic [7:0] a_in_data;
    logic       a_in_ready;
    logic       a_out_valid;
    logic [7:0] a_out_data;
    logic       a_out_ready;
    logic [1:0] a_count;

    logic       b_in_valid;
    logic [0:0] b_in_data;
    logic       b_in_ready;
    logic       b_out_valid;
    logic [0:0] b_out_data;
    logic       b_out_ready;
    logic [1:0] b_count;

    int checks;
    int errors;

    skid_buffer #(.WIDTH(8)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_ready (a_out_ready),
        .count     (a_count)
    );

    skid_buffer #(.WIDTH(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_ready (b_out_ready),
        .count     (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then examined 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asserts rst between clock edges and checks outputs before any edge.
    task automatic mid_cycle_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL %s_out_valid got %0b exp 0", tag, a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %0b exp 1", tag, a_in_ready); end
        checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL %s_count got %0d exp 0", tag, a_count); end
        checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL %s_out_data got %0h exp 00", tag, a_out_data); end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 1'b0;  b_out_ready = 1'b0;
        #2;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", a_in_ready); end
        checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", a_count); end
        checks++; if (b_count !== 2'd0) begin errors++; $display("FAIL reset_w1_count got %0d exp 0", b_count); end
        rst = 1'b0;
        // Load one word, then reset between edges.
        a_in_valid = 1'b1; a_in_data = 8'h33;
        step();
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_out_valid got %0b exp 1", a_out_valid); end
        mid_cycle_reset("async_reset");
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %0b exp 0", a_out_valid); end
    endtask

    task automatic test_single();
        a_in_valid = 1'b1; a_in_data = 8'h5A; a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0; a_in_data = 8'hFF;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %0b exp 1", a_out_valid); end
        checks++; if (a_out_data !== 8'h5A) begin errors++; $display("FAIL single_out_data got %0h exp 5a", a_out_data); end
        checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL single_count got %0d exp 1", a_count); end
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %0b exp 0", a_out_valid); end
        checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL single_drain_count got %0d exp 0", a_count); end
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h11;
        step();
        checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL bp_count1 got %0d exp 1", a_count); end
        a_in_data = 8'h22;
        step();
        checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL bp_count2 got %0d exp 2", a_count); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b exp 0", a_in_ready); end
        checks++; if (a_out_data !== 8'h11) begin errors++; $display("FAIL bp_head got %0h exp 11", a_out_data); end
        // Offered while full: must be ignored.
        a_in_data = 8'h99;
        step();
        checks++; if (a_out_data !== 8'h11) begin errors++; $display("FAIL bp_stable got %0h exp 11", a_out_data); end
        checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL bp_full_hold got %0d exp 2", a_count); end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        step();
        checks++; if (a_out_data !== 8'h22) begin errors++; $display("FAIL bp_second got %0h exp 22", a_out_data); end
        checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL bp_count_after got %0d exp 1", a_count); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after got %0b exp 1", a_in_ready); end
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b exp 0", a_out_valid); end
    endtask

    task automatic test_streaming();
        a_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(i);
            step();
            checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'(i)) begin errors++; $display("FAIL stream_word%0d got %0b/%0h exp 1/%0h", i, a_out_valid, a_out_data, i); end
            checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL stream_count%0d got %0d exp 1", i, a_count); end
        end
        a_in_valid = 1'b0;
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %0b exp 0", a_out_valid); end
    endtask

    task automatic test_reset_full();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'hAA;
        step();
        a_in_data = 8'hBB;
        step();
        a_in_valid = 1'b0;
        checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL rf_full got %0d exp 2", a_count); end
        mid_cycle_reset("rf_reset");
        a_in_valid = 1'b1; a_in_data = 8'hCC;
        step();
        a_in_valid = 1'b0;
        checks++; if (a_out_data !== 8'hCC || a_count !== 2'd1) begin errors++; $display("FAIL rf_first got %0h/%0d exp cc/1", a_out_data, a_count); end
        a_out_ready = 1'b1;
        step();
        checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL rf_drain got %0d exp 0", a_count); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_random(input bit narrow);
        logic [7:0] q[$];
        int         sent;
        int         got;
        int         cyc;
        logic       iv;
        logic       orr;
        logic [7:0] d;
        logic       ov;
        logic       ir;
        logic [7:0] od;
        logic [1:0] cnt;
        bit         in_acc;
        bit         out_acc;
        int         bad;
        string      tag;
        sent = 0; got = 0; cyc = 0; bad = 0;
        tag = narrow ? "rand_w1" : "rand_w8";
        while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
            iv  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            d   = narrow ? 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 255));
            orr = ($urandom_range(0, 2) != 0);
            if (narrow) begin
                b_in_valid = iv; b_in_data = d[0]; b_out_ready = orr;
            end else begin
                a_in_valid = iv; a_in_data = d; a_out_ready = orr;
            end
            in_acc  = iv && (q.size() < 2);
            out_acc = (q.size() > 0) && orr;
            step();
            cyc++;
            if (out_acc) begin void'(q.pop_front()); got++; end
            if (in_acc) begin q.push_back(d); sent++; end
            if (narrow) begin
                ov = b_out_valid; ir = b_in_ready; od = {7'd0, b_out_data}; cnt = b_count;
            end else begin
                ov = a_out_valid; ir = a_in_ready; od = a_out_data; cnt = a_count;
            end
            checks++;
            if (ov !== (q.size() > 0) || ir !== (q.size() < 2) || cnt !== 2'(q.size())) begin
                errors++; bad++;
                if (bad <= 5) $display("FAIL %s_ctrl cyc %0d got v%0b r%0b c%0d exp c%0d", tag, cyc, ov, ir, cnt, q.size());
            end
            if (q.size() > 0) begin
                checks++;
                if (od !== q[0]) begin
                    errors++; bad++;
                    if (bad <= 5) $display("FAIL %s_data cyc %0d got %0h exp %0h", tag, cyc, od, q[0]);
                end
            end
        end
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        checks++;
        if (sent != 1000 || got != 1000) begin
            errors++; $display("FAIL %s_total got sent %0d recv %0d exp 1000/1000", tag, sent, got);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_reset_full();
        test_random(1'b0);
        test_random(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/skid_buffer.md
SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 Parameter: WIDTH, default 8, data path width in bits; SHALL be >= 1.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  upstream asserts data available on in_data.
REQ-005 in_data  input  WIDTH  upstream payload, sampled when in_valid && in_ready.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 out_valid  output  1  out_data holds a valid word.
REQ-008 out_data  output  WIDTH  downstream payload.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 count  output  2  words held: 0, 1 or 2.

Function
REQ-011 Transfer SHALL occur on a port only in a cycle where its valid and ready are both high at the rising clk edge.
REQ-012 Storage SHALL be two WIDTH-bit registers: main (drives out_data) and skid (overflow).
REQ-013 State machine SHALL have three states: EMPTY (count 0), ONE (main valid), FULL (main and skid valid).
REQ-014 EMPTY: in transfer -> load main, go ONE; else stay.
REQ-015 ONE: in transfer with no out transfer -> load skid, go FULL.
REQ-016 ONE: out transfer with no in transfer -> go EMPTY.
REQ-017 ONE: simultaneous in and out transfer -> load main with in_data, stay ONE.
REQ-018 FULL: out transfer -> copy skid into main, go ONE; in transfer impossible because in_ready is low.
REQ-019 in_ready SHALL be a registered output, high in EMPTY and ONE, low in FULL; no combinational path from out_ready to in_ready.
REQ-020 out_valid SHALL be a registered output, high in ONE and FULL.
REQ-021 out_data SHALL come directly from the main register with no combinational path from in_data.
REQ-022 Latency SHALL be exactly 1 cycle from an in transfer into EMPTY to out_valid high.
REQ-023 Sustained throughput SHALL be 1 word/cycle when out_ready stays high.
REQ-024 Order SHALL be strict FIFO; no word SHALL be dropped or duplicated.
REQ-025 While out_valid is high and out_ready is low, out_data SHALL stay stable.
REQ-026 in_data SHALL be ignored when in_valid is low or in_ready is low.

Reset
REQ-027 On rst high, immediately and independent of clk: state EMPTY, count 0, out_valid 0, in_ready 1, main and skid cleared to 0.
REQ-028 Reset mid-operation SHALL discard all held words; the first transfer after rst deasserts SHALL behave as into EMPTY.
REQ-029 No transfer SHALL be accepted in any cycle where rst is high.

Structure
REQ-030 Shared package skid_pkg SHALL hold the state enum (EMPTY, ONE, FULL) and the count width constant (2).
REQ-031 One sub-module, data_reg, SHALL be used: a WIDTH-bit register with asynchronous active-high reset to 0 and load enable, instanced for main and skid.
REQ-032 The FSM and handshake logic SHALL live in skid_buffer itself; no other sub-modules.

Verification
REQ-033 Reset then idle: rst pulse mid-cycle -> out_valid=0, in_ready=1, count=0 without waiting for a clk edge.
REQ-034 Single word: in 0x5A with out_ready=1 -> out_valid high next cycle with out_data=0x5A, then EMPTY.
REQ-035 Back-pressure: out_ready=0, push 0x11 then 0x22 -> count=2, in_ready=0, out_data=0x11 held stable; release out_ready -> 0x11 then 0x22 in order.
REQ-036 Streaming: 16 words 0x00..0x0F with in_valid=1 and out_ready=1 -> 16 outputs in order, 1 per cycle, count never exceeds 1.
REQ-037 Random valid/ready (1000 words, WIDTH=8 and WIDTH=1) -> scoreboard exact order match, no loss or duplication, out_data stable under stall.
REQ-038 Reset in FULL (0xAA, 0xBB held) -> all cleared; next push 0xCC emerges first.
